// File: rtl/dispatch_lane_scheduler_if.sv
// Decode-to-reservation-station bus of the dispatch lane scheduler.
// The master modport is the upstream side (decode, flush and release sources).
// The slave modport is the scheduler itself.
interface dispatch_lane_scheduler_if #(
    parameter int FULL_DECODE_WIDTH = 158,
    parameter int LANES             = 4,
    parameter int CREDIT_WIDTH      = 4
);
    logic                          flush_i;
    logic                          decode_valid_i;
    logic                          decode_ready_o;
    logic [FULL_DECODE_WIDTH-1:0]  decode_instruction_i;
    logic [LANES-1:0]              rs_valid_o;
    logic [FULL_DECODE_WIDTH-1:0]  rs_instruction_o;
    logic [LANES-1:0]              rs_release_i;
    logic [LANES*CREDIT_WIDTH-1:0] lane_credits_o;
    logic                          credit_error_o;

    modport master (
        output flush_i, decode_valid_i, decode_instruction_i, rs_release_i,
        input  decode_ready_o, rs_valid_o, rs_instruction_o, lane_credits_o, credit_error_o
    );

    modport slave (
        input  flush_i, decode_valid_i, decode_instruction_i, rs_release_i,
        output decode_ready_o, rs_valid_o, rs_instruction_o, lane_credits_o, credit_error_o
    );
endinterface

// File: rtl/dispatch_lane_scheduler.sv
// Dispatch lane scheduler: steers one decoded instruction per cycle into a
// one-hot registered dispatch slot. Per-lane credit counters track free
// reservation-station entries. Decode is back-pressured when the target lane
// has no credit, and all credits return to full on a flush.
module dispatch_lane_scheduler #(
    parameter int FULL_DECODE_WIDTH = 158,
    parameter int LANE_INDEX_WIDTH  = 2,
    parameter int LANE_FIELD_LSB    = 0,
    parameter int RS_DEPTH          = 8,
    parameter int CREDIT_WIDTH      = $clog2(RS_DEPTH + 1)
) (
    input logic                      clock,
    input logic                      reset,
    dispatch_lane_scheduler_if.slave bus
);
    localparam int LANES = 2 ** LANE_INDEX_WIDTH;
    localparam logic [CREDIT_WIDTH-1:0] FULL_CREDIT = CREDIT_WIDTH'(RS_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] ONE_CREDIT  = CREDIT_WIDTH'(1);

    logic [LANE_INDEX_WIDTH-1:0]             lane;
    logic                                    decode_ready;
    logic                                    fire;
    logic [LANES-1:0]                        lane_dec;

    logic [LANES-1:0][CREDIT_WIDTH-1:0]      credit_q, credit_d;
    logic [LANES-1:0]                        rs_valid_q, rs_valid_d;
    logic [FULL_DECODE_WIDTH-1:0]            rs_instruction_q, rs_instruction_d;
    logic                                    credit_error_q, credit_error_d;

    // Target lane, handshake readiness and the one-hot lane hit for this cycle.
    assign lane         = bus.decode_instruction_i[LANE_FIELD_LSB +: LANE_INDEX_WIDTH];
    assign decode_ready = !reset && !bus.flush_i && (credit_q[lane] != '0);
    assign fire         = bus.decode_valid_i && decode_ready;
    assign lane_dec     = fire ? (LANES'(1) << lane) : '0;

    // Next-state for the dispatch slot, the credit counters and the error flag.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        credit_d         = credit_q;
        rs_valid_d       = '0;
        rs_instruction_d = rs_instruction_q;
        credit_error_d   = credit_error_q;

        if (bus.flush_i) begin
            // A flush empties every RS and cancels this cycle's fire and releases.
            for (int i = 0; i < LANES; i++) begin
                credit_d[i] = FULL_CREDIT;
            end
        end else begin
            if (fire) begin
                rs_valid_d       = lane_dec;
                rs_instruction_d = bus.decode_instruction_i;
            end
            for (int i = 0; i < LANES; i++) begin
                if (lane_dec[i] && !bus.rs_release_i[i]) begin
                    credit_d[i] = credit_q[i] - ONE_CREDIT;
                end else if (bus.rs_release_i[i] && !lane_dec[i]) begin
                    if (credit_q[i] == FULL_CREDIT) begin
                        credit_error_d = 1'b1;
                    end else begin
                        credit_d[i] = credit_q[i] + ONE_CREDIT;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset; reset outranks flush and fire.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                credit_q[i] <= FULL_CREDIT;
            end
            rs_valid_q <= '0;
            // NOTE: the wide instruction register is reset too, since its reset value is observable.
            rs_instruction_q <= '0;
            credit_error_q   <= 1'b0;
        end else begin
            credit_q         <= credit_d;
            rs_valid_q       <= rs_valid_d;
            rs_instruction_q <= rs_instruction_d;
            credit_error_q   <= credit_error_d;
        end
    end

    assign bus.decode_ready_o   = decode_ready;
    assign bus.rs_valid_o       = rs_valid_q;
    assign bus.rs_instruction_o = rs_instruction_q;
    assign bus.lane_credits_o   = credit_q;
    assign bus.credit_error_o   = credit_error_q;
endmodule

// File: tb/tb_dispatch_lane_scheduler.sv
// Self-checking bench for dispatch_lane_scheduler: a table of directed
// vectors followed by hand-written multi-cycle sequences.
module tb_dispatch_lane_scheduler;
    localparam int W     = 158;
    localparam int LIW   = 2;
    localparam int LANES = 4;
    localparam int CW    = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dispatch_lane_scheduler_if #(.FULL_DECODE_WIDTH(W), .LANES(LANES), .CREDIT_WIDTH(CW)) bus ();

    dispatch_lane_scheduler #(
        .FULL_DECODE_WIDTH(W),
        .LANE_INDEX_WIDTH (LIW),
        .LANE_FIELD_LSB   (0),
        .RS_DEPTH         (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  lane;
        logic        valid;
        logic [3:0]  rel;
        logic        flush;
        logic        exp_ready;
        logic [3:0]  exp_rs;
        logic [15:0] exp_cred;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];
    logic [W-1:0] cur;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] make_instr(input int seed, input logic [1:0] lane);
        logic [159:0] v;
        for (int k = 0; k < 5; k++) begin
            v[k*32 +: 32] = 32'h9E37_79B9 * (seed * 7 + k + 1);
        end
        v[1:0] = lane;
        return v[W-1:0];
    endfunction

    function automatic vec_t mk(input logic [1:0] lane, input logic valid, input logic [3:0] rel,
                                input logic flush, input logic exp_ready, input logic [3:0] exp_rs,
                                input logic [15:0] exp_cred, input logic exp_err);
        vec_t v;
        v.lane = lane; v.valid = valid; v.rel = rel; v.flush = flush;
        v.exp_ready = exp_ready; v.exp_rs = exp_rs; v.exp_cred = exp_cred; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input logic valid, input logic [W-1:0] instr, input logic [3:0] rel, input logic flush);
        bus.decode_valid_i       = valid;
        bus.decode_instruction_i = instr;
        bus.rs_release_i         = rel;
        bus.flush_i              = flush;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, make_instr(99, 2'd0), 4'b0, 1'b0);
        #1;
        check("ready_in_reset", 160'(bus.decode_ready_o), 160'(1'b0));
        step();
        step();
        check("reset_rs_valid", 160'(bus.rs_valid_o), 160'(4'b0));
        check("reset_instr", 160'(bus.rs_instruction_o), 160'(0));
        check("reset_credits", 160'(bus.lane_credits_o), 160'(16'h8888));
        check("reset_err", 160'(bus.credit_error_o), 160'(1'b0));
        reset = 1'b0;
        drive(1'b0, '0, 4'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 4'b0, 1'b0);

        //        lane  val rel      fl   rdy  rs       credits   err
        vecs[0]  = mk(2'd2, 1, 4'b0000, 0, 1, 4'b0100, 16'h8788, 0);
        vecs[1]  = mk(2'd0, 1, 4'b0000, 0, 1, 4'b0001, 16'h8787, 0);
        vecs[2]  = mk(2'd0, 1, 4'b0000, 0, 1, 4'b0001, 16'h8786, 0);
        vecs[3]  = mk(2'd0, 1, 4'b0000, 0, 1, 4'b0001, 16'h8785, 0);
        vecs[4]  = mk(2'd0, 1, 4'b0000, 0, 1, 4'b0001, 16'h8784, 0);
        vecs[5]  = mk(2'd0, 1, 4'b0000, 0, 1, 4'b0001, 16'h8783, 0);
        vecs[6]  = mk(2'd3, 1, 4'b0000, 0, 1, 4'b1000, 16'h7783, 0);
        vecs[7]  = mk(2'd3, 1, 4'b0000, 0, 1, 4'b1000, 16'h6783, 0);
        vecs[8]  = mk(2'd3, 1, 4'b0000, 0, 1, 4'b1000, 16'h5783, 0);
        vecs[9]  = mk(2'd0, 1, 4'b1001, 0, 1, 4'b0001, 16'h6783, 0);
        vecs[10] = mk(2'd1, 0, 4'b0100, 0, 1, 4'b0000, 16'h6883, 0);
        vecs[11] = mk(2'd0, 0, 4'b0100, 0, 1, 4'b0000, 16'h6883, 1);
        vecs[12] = mk(2'd3, 1, 4'b0000, 1, 0, 4'b0000, 16'h8888, 1);
        vecs[13] = mk(2'd1, 1, 4'b0000, 0, 1, 4'b0010, 16'h8878, 1);
        vecs[14] = mk(2'd1, 1, 4'b0010, 1, 0, 4'b0000, 16'h8888, 1);

        do_reset();

        // Table-driven vectors, applied back to back.
        for (int i = 0; i < 15; i++) begin
            cur = make_instr(i, vecs[i].lane);
            drive(vecs[i].valid, cur, vecs[i].rel, vecs[i].flush);
            #1;
            check($sformatf("v%0d_ready", i), 160'(bus.decode_ready_o), 160'(vecs[i].exp_ready));
            step();
            check($sformatf("v%0d_rs_valid", i), 160'(bus.rs_valid_o), 160'(vecs[i].exp_rs));
            check($sformatf("v%0d_credits", i), 160'(bus.lane_credits_o), 160'(vecs[i].exp_cred));
            check($sformatf("v%0d_err", i), 160'(bus.credit_error_o), 160'(vecs[i].exp_err));
            if (vecs[i].exp_rs != 4'b0)
                check($sformatf("v%0d_instr", i), 160'(bus.rs_instruction_o), 160'(cur));
        end
        drive(1'b0, '0, 4'b0, 1'b0);

        // Lane 1 exhaustion, back-pressure and recovery by one release.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cur = make_instr(100 + k, 2'd1);
            drive(1'b1, cur, 4'b0, 1'b0);
            #1;
            check($sformatf("b2b%0d_ready", k), 160'(bus.decode_ready_o), 160'(1'b1));
            step();
            check($sformatf("b2b%0d_rs_valid", k), 160'(bus.rs_valid_o), 160'(4'b0010));
            check($sformatf("b2b%0d_instr", k), 160'(bus.rs_instruction_o), 160'(cur));
            check($sformatf("b2b%0d_credit1", k), 160'(bus.lane_credits_o[7:4]), 160'(7 - k));
        end
        cur = make_instr(200, 2'd1);
        drive(1'b1, cur, 4'b0, 1'b0);
        #1;
        check("ninth_ready_low", 160'(bus.decode_ready_o), 160'(1'b0));
        step();
        check("ninth_stalled", 160'(bus.rs_valid_o), 160'(4'b0));
        drive(1'b1, cur, 4'b0010, 1'b0);
        #1;
        check("release_cycle_ready_low", 160'(bus.decode_ready_o), 160'(1'b0));
        step();
        drive(1'b1, cur, 4'b0000, 1'b0);
        #1;
        check("after_release_credits", 160'(bus.lane_credits_o), 160'(16'h8818));
        check("after_release_ready", 160'(bus.decode_ready_o), 160'(1'b1));
        step();
        check("ninth_dispatch", 160'(bus.rs_valid_o), 160'(4'b0010));
        check("ninth_instr", 160'(bus.rs_instruction_o), 160'(cur));
        check("ninth_credits", 160'(bus.lane_credits_o), 160'(16'h8808));
        drive(1'b0, '0, 4'b0, 1'b0);

        // Four lane-3 dispatches, then a flush with valid held high.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, make_instr(300 + k, 2'd3), 4'b0, 1'b0);
            step();
        end
        check("pre_flush_credits", 160'(bus.lane_credits_o), 160'(16'h4888));
        drive(1'b1, make_instr(310, 2'd3), 4'b0, 1'b1);
        #1;
        check("flush_ready_low", 160'(bus.decode_ready_o), 160'(1'b0));
        step();
        check("flush_rs_valid", 160'(bus.rs_valid_o), 160'(4'b0));
        check("flush_credits", 160'(bus.lane_credits_o), 160'(16'h8888));
        drive(1'b0, '0, 4'b0, 1'b0);

        // Sticky credit error: set by an over-release, survives flush, cleared by reset.
        do_reset();
        drive(1'b0, '0, 4'b0100, 1'b0);
        step();
        check("over_release_credits", 160'(bus.lane_credits_o), 160'(16'h8888));
        check("over_release_err", 160'(bus.credit_error_o), 160'(1'b1));
        drive(1'b0, '0, 4'b0, 1'b1);
        step();
        check("err_after_flush", 160'(bus.credit_error_o), 160'(1'b1));
        drive(1'b0, '0, 4'b0, 1'b0);
        do_reset();

        // Reset in the cycle after a fire drops the pending dispatch state.
        cur = make_instr(400, 2'd2);
        drive(1'b1, cur, 4'b0, 1'b0);
        step();
        check("pre_reset_rs_valid", 160'(bus.rs_valid_o), 160'(4'b0100));
        reset = 1'b1;
        #1;
        check("mid_reset_ready", 160'(bus.decode_ready_o), 160'(1'b0));
        step();
        check("mid_reset_rs_valid", 160'(bus.rs_valid_o), 160'(4'b0));
        check("mid_reset_credits", 160'(bus.lane_credits_o), 160'(16'h8888));
        check("mid_reset_instr", 160'(bus.rs_instruction_o), 160'(0));
        reset = 1'b0;
        drive(1'b0, '0, 4'b0, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dispatch_lane_scheduler.md
Name: dispatch_lane_scheduler

Overview:
- Sits between decode_stage64 and the EXECUTION_LANES reservation stations (RS) of the out-of-order core.
- Takes one decoded instruction per cycle over a valid/ready handshake and reads its lane index field.
- Tracks free RS entries per lane with credit counters and steers the instruction into a registered one-hot dispatch slot.
- Back-pressures decode when the target lane has no credit, and restores all credits on a pipeline flush.

Parameters:
- FULL_DECODE_WIDTH, 158: width of a decoded instruction.
- LANE_INDEX_WIDTH, 2: width of the lane index field; LANES = 2**LANE_INDEX_WIDTH.
- LANE_FIELD_LSB, 0: bit position of the lane index inside decode_instruction_i.
- RS_DEPTH, 8: entries per reservation station, which is also the initial credit per lane.
- CREDIT_WIDTH, $clog2(RS_DEPTH+1): width of each credit counter.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  pipeline flush; all RSs are flushed in the same cycle.
- decode_valid_i  input  1  decoded instruction valid.
- decode_ready_o  output  1  scheduler can accept the instruction this cycle.
- decode_instruction_i  input  FULL_DECODE_WIDTH  decoded instruction.
- rs_valid_o  output  LANES  one-hot write strobe to lane RS; no ready, because credit guarantees space.
- rs_instruction_o  output  FULL_DECODE_WIDTH  registered instruction shared by all lanes.
- rs_release_i  input  LANES  per-lane pulse; one RS entry freed (issued) this cycle.
- lane_credits_o  output  LANES*CREDIT_WIDTH  packed credit counters, lane 0 in the LSBs.
- credit_error_o  output  1  sticky flag: release received while that lane was already at RS_DEPTH.

Behaviour:
- lane = decode_instruction_i[LANE_FIELD_LSB +: LANE_INDEX_WIDTH].
- decode_ready_o is combinational: !reset && !flush_i && credit[lane] != 0. It depends on input data, and decode holds its data stable while valid.
- Fire = decode_valid_i && decode_ready_o.
- On fire, at the next posedge:
  - rs_valid_o = one-hot(lane);
  - rs_instruction_o = decode_instruction_i;
  - credit[lane] decrements.
- Latency is 1 cycle from fire to rs_valid_o. Throughput is 1 instruction per cycle, including back-to-back to the same lane while credit allows.
- Without fire, rs_valid_o = 0 at the next posedge. rs_instruction_o holds its last value and is don't-care when rs_valid_o = 0.
- Per-lane credit update each cycle, with dec = fire for this lane and inc = rs_release_i[lane]:
  - dec && inc: unchanged.
  - dec only: -1. Cannot underflow, because ready requires credit != 0.
  - inc only: +1, saturating at RS_DEPTH. A release at RS_DEPTH leaves credit at RS_DEPTH and sets credit_error_o.
- Releases on multiple lanes in the same cycle are all applied independently.
- flush_i = 1, at the next posedge:
  - all credits = RS_DEPTH;
  - rs_valid_o = 0;
  - no fire this cycle;
  - rs_release_i ignored this cycle;
  - credit_error_o unchanged.
- flush_i has priority over fire and release. reset has priority over flush_i.
- Reset values:
  - rs_valid_o = 0;
  - rs_instruction_o = 0;
  - all credits = RS_DEPTH;
  - credit_error_o = 0;
  - decode_ready_o = 0 while reset = 1.
- Reset asserted mid-stream: any in-flight rs_valid_o pulse is dropped and credits return to full at that posedge.
- credit_error_o clears only on reset.
- No internal FSM beyond the credit counters and the dispatch register. Width arithmetic is unsigned CREDIT_WIDTH.

Test Plan:
- Reset, then an instruction with lane field 2 and decode_valid_i=1 -> decode_ready_o=1; next cycle rs_valid_o=4'b0100, rs_instruction_o matches input, lane_credits_o lane2=7, other lanes=8.
- 8 back-to-back lane-1 instructions, no release -> rs_valid_o=4'b0010 for 8 consecutive cycles, lane1 credit=0, decode_ready_o=0 for the 9th; one rs_release_i[1] pulse -> ready=1 next cycle, the 9th dispatches, credit returns to 0.
- Lane 0 at credit 3, fire to lane 0 with rs_release_i[0]=1 in the same cycle -> credit stays 3; a simultaneous rs_release_i[3] on lane 3 at 5 -> 6.
- After 4 dispatches to lane 3, assert flush_i with decode_valid_i=1 -> decode_ready_o=0 that cycle, next cycle rs_valid_o=0, all credits=8.
- rs_release_i[2] with lane2 credit=8 -> credit stays 8, credit_error_o=1 and stays 1 through a flush; reset -> 0.
- Assert reset in the cycle after a fire -> rs_valid_o=0 at the next posedge, credits all 8, rs_instruction_o=0.
